// File: rtl/prng_arbiter.sv
// Round-robin arbiter that shares one external PRNG between NREQ requesters,
// chaining each result into the next seed and bounding every PRNG wait.
//
// state   | meaning
// IDLE    | no transaction; pick round-robin winner when any req is high
// START   | launch PRNG with the issued seed (prng_start pulse)
// WAIT    | wait for prng_done, give up after TIMEOUT cycles
// RESP    | one-cycle rsp_valid to the granted requester
module prng_arbiter #(
    parameter int N = 16,
    parameter int NREQ = 4,
    parameter int TIMEOUT = 64,
    parameter logic [N-1:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rsp_valid,
    output logic [N-1:0]    rsp_data,
    output logic            rsp_err,
    input  logic            seed_load,
    input  logic [N-1:0]    seed_in,
    output logic            prng_start,
    output logic [N-1:0]    prng_seed,
    input  logic            prng_done,
    input  logic [N-1:0]    prng_out,
    output logic            busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t          state, state_next;
    logic [N-1:0]    seed_reg;
    logic [N-1:0]    seed_issued;
    logic            seed_pinned;
    logic [IW-1:0]   last_served;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] grant_next;
    logic [CW-1:0]   wait_cnt;
    logic            wait_expired;

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        logic found;
        found = 1'b0;
        grant_next = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(last_served) + i) % NREQ]) begin
                grant_next[(int'(last_served) + i) % NREQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (|req) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (prng_done || wait_expired) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        prng_start = 1'b0;
        prng_seed  = '0;
        rsp_valid  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_START: begin
                prng_start = 1'b1;
                prng_seed  = seed_issued;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // A seed loaded after the current seed was issued is pinned so the
    // chained PRNG result of that transaction does not overwrite it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt         <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            seed_reg    <= SEED_DEFAULT;
            seed_issued <= '0;
            seed_pinned <= 1'b0;
            last_served <= LAST_INIT;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt         <= grant_next;
                        seed_issued <= (seed_reg == '0) ? SEED_DEFAULT : seed_reg;
                        seed_pinned <= 1'b0;
                    end
                end
                S_START: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (prng_done) begin
                        rsp_data <= prng_out;
                        rsp_err  <= 1'b0;
                        if (!seed_pinned) seed_reg <= prng_out;
                    end else if (wait_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    last_served <= gnt_idx;
                    gnt         <= '0;
                end
                default: ;
            endcase
            if (seed_load) begin
                seed_reg    <= seed_in;
                seed_pinned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: a 3-cycle seed+1 PRNG model feeds the
// DUT and a scoreboard queue holds the expected response of every transaction.
module tb_prng_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        prng_start;
    logic [15:0] prng_seed;
    logic        prng_done = 1'b0;
    logic [15:0] prng_out = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [15:0] data;
        logic        err;
    } sb_t;
    sb_t sb[$];

    bit          model_en = 1'b1;
    int          dcnt = 0;
    logic [15:0] mseed = '0;

    prng_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .seed_load(seed_load), .seed_in(seed_in),
        .prng_start(prng_start), .prng_seed(prng_seed),
        .prng_done(prng_done), .prng_out(prng_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // PRNG model: done three cycles after start, result = seed + 1
    always @(negedge clk) begin
        prng_done = 1'b0;
        if (!reset) begin
            dcnt = 0;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    prng_done = 1'b1;
                    prng_out  = mseed + 16'd1;
                end
            end
            if (prng_start && model_en) begin
                dcnt  = 3;
                mseed = prng_seed;
            end
        end
    end

    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected gnt=%b data=%h err=%b required no response", gnt, rsp_data, rsp_err);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (gnt !== e.gnt || rsp_data !== e.data || rsp_err !== e.err) begin
                    failures++;
                    $display("FAIL rsp got gnt=%b data=%h err=%b required gnt=%b data=%h err=%b",
                             gnt, rsp_data, rsp_err, e.gnt, e.data, e.err);
                end
            end
        end
    end

    // mode: 0 drop req after response, 1 keep req, 2 drop req right after grant
    task automatic do_txn(input logic [3:0] r, input logic [3:0] eg, input logic [15:0] es,
                          input logic [15:0] ed, input logic ee, input int elat,
                          input int mode, input int load_at, input logic [15:0] load_val);
        sb_t e;
        int  k;
        bit  got;
        e.gnt = eg; e.data = ed; e.err = ee;
        sb.push_back(e);
        req = r;
        @(negedge clk);
        checks++;
        if (gnt !== eg) begin
            failures++;
            $display("FAIL grant got=%b required=%b", gnt, eg);
        end
        checks++;
        if (prng_start !== 1'b1 || prng_seed !== es) begin
            failures++;
            $display("FAIL start got start=%b seed=%h required start=1 seed=%h", prng_start, prng_seed, es);
        end
        if (mode == 2) req = '0;
        got = 1'b0;
        k = 0;
        while (!got && k < 200) begin
            k++;
            @(negedge clk);
            seed_load = (k == load_at);
            seed_in   = load_val;
            if (rsp_valid) got = 1'b1;
        end
        seed_load = 1'b0;
        checks++;
        if (!got || k != elat) begin
            failures++;
            $display("FAIL latency got=%0d seen=%0b required=%0d", k, got, elat);
        end
        if (mode != 1) req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after got gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 ||
            prng_start !== 1'b0 || prng_seed !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got gnt=%b v=%b d=%h e=%b st=%b sd=%h busy=%b required all zero",
                     gnt, rsp_valid, rsp_data, rsp_err, prng_start, prng_seed, busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_contention();
        do_txn(4'b1111, 4'b0001, 16'hACE1, 16'hACE2, 1'b0, 4, 1, 0, 16'h0);
        do_txn(4'b1111, 4'b0010, 16'hACE2, 16'hACE3, 1'b0, 4, 1, 0, 16'h0);
        do_txn(4'b1111, 4'b0100, 16'hACE3, 16'hACE4, 1'b0, 4, 1, 0, 16'h0);
        do_txn(4'b1111, 4'b1000, 16'hACE4, 16'hACE5, 1'b0, 4, 0, 0, 16'h0);
    endtask

    task automatic test_single();
        do_txn(4'b0010, 4'b0010, 16'hACE1, 16'hACE2, 1'b0, 4, 2, 0, 16'h0);
        @(negedge clk);
        checks++;
        if (rsp_data !== 16'hACE2 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rsp_hold got data=%h err=%b required data=ace2 err=0", rsp_data, rsp_err);
        end
    endtask

    task automatic test_reseed();
        do_txn(4'b0110, 4'b0100, 16'hACE2, 16'hACE3, 1'b0, 4, 0, 1, 16'h1234);
        do_txn(4'b0001, 4'b0001, 16'h1234, 16'h1235, 1'b0, 4, 0, 3, 16'h5555);
        do_txn(4'b0001, 4'b0001, 16'h5555, 16'h5556, 1'b0, 4, 0, 0, 16'h0);
    endtask

    task automatic test_zero_seed();
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        do_txn(4'b0100, 4'b0100, 16'hACE1, 16'hACE2, 1'b0, 4, 0, 0, 16'h0);
    endtask

    task automatic test_timeout();
        model_en = 1'b0;
        do_txn(4'b1000, 4'b1000, 16'hACE2, 16'h0000, 1'b1, 65, 0, 0, 16'h0);
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 16'h0) begin
            failures++;
            $display("FAIL err_hold got data=%h err=%b required data=0000 err=1", rsp_data, rsp_err);
        end
        model_en = 1'b1;
        do_txn(4'b1001, 4'b0001, 16'hACE2, 16'hACE3, 1'b0, 4, 0, 0, 16'h0);
        do_txn(4'b1001, 4'b1000, 16'hACE3, 16'hACE4, 1'b0, 4, 0, 0, 16'h0);
    endtask

    task automatic test_reset_mid_wait();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL mid_grant got=%b required=0100", gnt);
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 ||
            prng_start !== 1'b0 || prng_seed !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got gnt=%b v=%b d=%h e=%b st=%b sd=%h busy=%b required all zero",
                     gnt, rsp_valid, rsp_data, rsp_err, prng_start, prng_seed, busy);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_quiet got v=%b busy=%b required 0 0", rsp_valid, busy);
            end
        end
        reset = 1'b1;
        do_txn(4'b1111, 4'b0001, 16'hACE1, 16'hACE2, 1'b0, 4, 0, 0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_reset();
        test_single();
        test_reseed();
        test_zero_seed();
        test_timeout();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 Parameter N, default 16: seed and random-word width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 64: maximum cycles to wait for prng_done.
REQ-004 Parameter SEED_DEFAULT, default 16'hACE1: nonzero seed used after reset and in place of any zero seed.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  level request per requester, held until its response.
REQ-008 gnt  output  NREQ  one-hot grant to the requester currently served.
REQ-009 rsp_valid  output  1  one-cycle pulse: rsp_data valid for the granted requester.
REQ-010 rsp_data  output  N  random word delivered with rsp_valid.
REQ-011 rsp_err  output  1  qualifies rsp_valid: 1 = PRNG timeout, and rsp_data is 0.
REQ-012 seed_load  input  1  one-cycle strobe: load seed_in as the next seed.
REQ-013 seed_in  input  N  external seed value.
REQ-014 prng_start  output  1  one-cycle pulse that launches the shared PRNG.
REQ-015 prng_seed  output  N  seed presented to the PRNG, valid while prng_start=1.
REQ-016 prng_done  input  1  PRNG completion flag.
REQ-017 prng_out  input  N  PRNG result, sampled when prng_done=1.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, START, WAIT, RESP.
- IDLE -> START when req != 0.
- START -> WAIT unconditionally.
- WAIT -> RESP on prng_done or on timeout.
- RESP -> IDLE unconditionally.
REQ-020 In IDLE with req != 0, the arbiter registers a one-hot gnt to the round-robin winner.
- Search starts at index (last_served+1) mod NREQ and proceeds upward with wrap.
- last_served resets to NREQ-1, so index 0 wins first.
REQ-021 gnt holds from START through RESP inclusive and is 0 in IDLE.
REQ-022 prng_start = 1 only in START; prng_seed = seed_reg in START, else 0.
REQ-023 Seed substitution: if seed_reg = 0 when START is entered, prng_seed carries SEED_DEFAULT instead.
REQ-024 WAIT counter:
- Clears on entering WAIT and increments each WAIT cycle.
- If it reaches TIMEOUT with no prng_done, the FSM goes to RESP with rsp_err=1 and rsp_data=0.
- seed_reg is left unchanged on timeout.
REQ-025 On prng_done in WAIT:
- rsp_data <= prng_out and rsp_err <= 0.
- seed_reg <= prng_out, chaining the next transaction's seed.
REQ-026 prng_done outside WAIT is ignored.
REQ-027 In RESP, rsp_valid = 1 for exactly one cycle and last_served <= index of gnt.
REQ-028 Latency: req sampled in IDLE at cycle t gives gnt and prng_start at t+1. prng_done at cycle d gives rsp_valid at d+1.
REQ-029 seed_load is accepted in every state and sets seed_reg <= seed_in.
- If it coincides with prng_done, seed_in wins over the chain update.
- It never alters a prng_seed already issued.
REQ-030 A requester that drops req after being granted still receives its rsp_valid pulse and still counts as served.
REQ-031 New req bits arriving during START, WAIT or RESP are not arbitrated until the next IDLE.
REQ-032 rsp_data and rsp_err hold their last values until the next RESP.

Reset
REQ-033 When reset = 0, the block asynchronously sets:
- state = IDLE, gnt = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0;
- prng_start = 0, prng_seed = 0, busy = 0;
- seed_reg = SEED_DEFAULT, last_served = NREQ-1, WAIT counter = 0.
REQ-034 Reset asserted mid-transaction abandons that transaction with no rsp_valid. After release the block restarts from IDLE.

Verification
REQ-035 Single request: PRNG model asserts done 3 cycles after start with out = seed+1. req=4'b0010 at t -> gnt=0010 and prng_start with prng_seed=16'hACE1 at t+1; rsp_valid with rsp_data=16'hACE2 and rsp_err=0 at t+5.
REQ-036 Contention: req=4'b1111 held for 4 transactions -> grant order 0,1,2,3; returned words chain ACE2, ACE3, ACE4, ACE5.
REQ-037 Reseed: seed_load with seed_in=16'h1234 during WAIT -> current response is unaffected; next prng_seed=16'h1234. seed_load coincident with prng_done -> next seed is seed_in.
REQ-038 Zero seed: seed_load with seed_in=0, then a request -> prng_seed=16'hACE1.
REQ-039 Timeout: PRNG model never asserts done -> rsp_valid with rsp_err=1 and rsp_data=0 exactly TIMEOUT cycles after entering WAIT; next transaction reuses the unchanged seed.
REQ-040 Reset mid-WAIT: reset=0 for 2 cycles -> all outputs at reset values immediately, no rsp_valid; a request after release is granted to index 0 with prng_seed=16'hACE1.
